// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // Full shadow of an instruction sitting in EX
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwren;
        logic              memren;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              rs1_used;
        logic              rs2_used;
    } stage_entry_t;

    // MEM only needs to know what it writes and whether it is a load
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwren;
        logic              memren;
    } mem_entry_t;

    // WB only needs to know what it writes
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwren;
    } wb_entry_t;

    localparam stage_entry_t EX_BUBBLE  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    localparam mem_entry_t   MEM_BUBBLE = '{1'b0, 5'd0, 1'b0, 1'b0};
    localparam wb_entry_t    WB_BUBBLE  = '{1'b0, 5'd0, 1'b0};

endpackage

// File: rtl/hazard_ctrl_reg_match.sv
// Register-dependency compare: a valid writer of rd hits a used source index.
// x0 is hard-wired zero and never creates a dependency.
module reg_match
    import hazard_ctrl_pkg::*;
(
    input  logic              valid_i,
    input  logic              regwren_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic              used_i,
    output logic              match_o
);

    assign match_o = valid_i & regwren_i & used_i
                   & (rd_i != 5'd0) & (rd_i == rs_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows the EX/MEM/WB occupants, decides
// stall/flush for decode and selects EX operand forwarding sources.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int CWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_regwren_i,
    input  logic              id_memren_i,
    input  logic              ex_redirect_i,
    input  logic              dmem_busy_i,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CWIDTH-1:0] stall_cnt_o,
    output logic [CWIDTH-1:0] flush_cnt_o
);

    localparam logic [CWIDTH-1:0] CNT_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

    stage_entry_t      ex_q,  ex_d;
    mem_entry_t        mem_q, mem_d;
    wb_entry_t         wb_q,  wb_d;
    logic [CWIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CWIDTH-1:0] flush_cnt_q, flush_cnt_d;

    stage_entry_t id_entry_s;
    mem_entry_t   ex_to_mem_s;
    wb_entry_t    mem_to_wb_s;
    fwd_sel_e     fwd_a_s, fwd_b_s;

    logic ex_rs1_s, ex_rs2_s, mem_rs1_s, mem_rs2_s;
    logic fa_mem_s, fb_mem_s, fa_wb_s, fb_wb_s;
    logic load_use_s, raw_s, hazard_s;

    assign id_entry_s = '{id_valid_i, id_rd_i, id_regwren_i, id_memren_i,
                          id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i};
    assign ex_to_mem_s = '{ex_q.valid, ex_q.rd, ex_q.regwren, ex_q.memren};
    assign mem_to_wb_s = '{mem_q.valid, mem_q.rd, mem_q.regwren};

    // Decode sources against the EX and MEM writers
    reg_match u_m_ex_rs1  (.valid_i(ex_q.valid),  .regwren_i(ex_q.regwren),  .rd_i(ex_q.rd),
                           .rs_i(id_rs1_i), .used_i(id_rs1_used_i), .match_o(ex_rs1_s));
    reg_match u_m_ex_rs2  (.valid_i(ex_q.valid),  .regwren_i(ex_q.regwren),  .rd_i(ex_q.rd),
                           .rs_i(id_rs2_i), .used_i(id_rs2_used_i), .match_o(ex_rs2_s));
    reg_match u_m_mem_rs1 (.valid_i(mem_q.valid), .regwren_i(mem_q.regwren), .rd_i(mem_q.rd),
                           .rs_i(id_rs1_i), .used_i(id_rs1_used_i), .match_o(mem_rs1_s));
    reg_match u_m_mem_rs2 (.valid_i(mem_q.valid), .regwren_i(mem_q.regwren), .rd_i(mem_q.rd),
                           .rs_i(id_rs2_i), .used_i(id_rs2_used_i), .match_o(mem_rs2_s));

    // EX sources against the MEM and WB writers (forwarding)
    reg_match u_f_mem_a (.valid_i(mem_q.valid), .regwren_i(mem_q.regwren), .rd_i(mem_q.rd),
                         .rs_i(ex_q.rs1), .used_i(ex_q.rs1_used), .match_o(fa_mem_s));
    reg_match u_f_mem_b (.valid_i(mem_q.valid), .regwren_i(mem_q.regwren), .rd_i(mem_q.rd),
                         .rs_i(ex_q.rs2), .used_i(ex_q.rs2_used), .match_o(fb_mem_s));
    reg_match u_f_wb_a  (.valid_i(wb_q.valid),  .regwren_i(wb_q.regwren),  .rd_i(wb_q.rd),
                         .rs_i(ex_q.rs1), .used_i(ex_q.rs1_used), .match_o(fa_wb_s));
    reg_match u_f_wb_b  (.valid_i(wb_q.valid),  .regwren_i(wb_q.regwren),  .rd_i(wb_q.rd),
                         .rs_i(ex_q.rs2), .used_i(ex_q.rs2_used), .match_o(fb_wb_s));

    assign load_use_s = id_valid_i & ex_q.memren & (ex_rs1_s | ex_rs2_s);
    assign raw_s      = id_valid_i & (ex_rs1_s | ex_rs2_s | mem_rs1_s | mem_rs2_s);
    assign hazard_s   = (FWD_EN == 1'b1) ? load_use_s : raw_s;

    // Priority decision, shadow advance, counter next-state and forwarding selects
    always_comb begin
        stall_f_o   = 1'b0;
        stall_d_o   = 1'b0;
        flush_d_o   = 1'b0;
        flush_e_o   = 1'b0;
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        fwd_a_s     = FWD_RF;
        fwd_b_s     = FWD_RF;

        if (rst) begin
            // Keep the pipe empty while reset is held
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (dmem_busy_i) begin
            // Whole pipe frozen; a pending redirect stays pending in EX
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
        end else if (ex_redirect_i) begin
            // Wrong-path instructions in F/D and D/E are squashed
            flush_d_o   = 1'b1;
            flush_e_o   = 1'b1;
            ex_d        = EX_BUBBLE;
            mem_d       = ex_to_mem_s;
            wb_d        = mem_to_wb_s;
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else if (hazard_s) begin
            // Hold decode, drop a bubble into EX
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
            ex_d      = EX_BUBBLE;
            mem_d     = ex_to_mem_s;
            wb_d      = mem_to_wb_s;
        end else begin
            ex_d  = id_entry_s;
            mem_d = ex_to_mem_s;
            wb_d  = mem_to_wb_s;
        end

        if (!rst && stall_d_o) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        // Younger producer (MEM) wins; a load result is not yet available in MEM
        if (!rst && (FWD_EN == 1'b1) && ex_q.valid) begin
            if (fa_mem_s && !mem_q.memren) begin
                fwd_a_s = FWD_MEM;
            end else if (fa_wb_s) begin
                fwd_a_s = FWD_WB;
            end else begin
                fwd_a_s = FWD_RF;
            end
            if (fb_mem_s && !mem_q.memren) begin
                fwd_b_s = FWD_MEM;
            end else if (fb_wb_s) begin
                fwd_b_s = FWD_WB;
            end else begin
                fwd_b_s = FWD_RF;
            end
        end else begin
            fwd_a_s = FWD_RF;
            fwd_b_s = FWD_RF;
        end
    end

    assign fwd_a_o     = fwd_a_s;
    assign fwd_b_o     = fwd_b_s;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // Shadow scoreboard and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= EX_BUBBLE;
            mem_q       <= MEM_BUBBLE;
            wb_q        <= WB_BUBBLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table on a forwarding instance,
// hand sequences on a non-forwarding, narrow-counter instance.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [4:0] rs1;
        logic       rs1_used;
        logic [4:0] rs2;
        logic       rs2_used;
        logic [4:0] rd;
        logic       regwren;
        logic       memren;
        logic       redirect;
        logic       busy;
    } in_t;

    typedef struct packed {
        logic        sf;
        logic        sd;
        logic        fd;
        logic        fe;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        chk_cnt;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic clk;
    in_t  in0, in1;
    int   errors;
    int   checks;

    logic        sf0, sd0, fd0, fe0;
    logic [1:0]  fa0, fb0;
    logic [31:0] sc0, fc0;
    logic        sf1, sd1, fd1, fe1;
    logic [1:0]  fa1, fb1;
    logic [3:0]  sc1, fc1;

    hazard_ctrl #(.FWD_EN(1'b1), .CWIDTH(32)) dut0 (
        .clk(clk), .rst(in0.rst), .id_valid_i(in0.id_valid),
        .id_rs1_i(in0.rs1), .id_rs2_i(in0.rs2),
        .id_rs1_used_i(in0.rs1_used), .id_rs2_used_i(in0.rs2_used),
        .id_rd_i(in0.rd), .id_regwren_i(in0.regwren), .id_memren_i(in0.memren),
        .ex_redirect_i(in0.redirect), .dmem_busy_i(in0.busy),
        .stall_f_o(sf0), .stall_d_o(sd0), .flush_d_o(fd0), .flush_e_o(fe0),
        .fwd_a_o(fa0), .fwd_b_o(fb0), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
    );

    hazard_ctrl #(.FWD_EN(1'b0), .CWIDTH(4)) dut1 (
        .clk(clk), .rst(in1.rst), .id_valid_i(in1.id_valid),
        .id_rs1_i(in1.rs1), .id_rs2_i(in1.rs2),
        .id_rs1_used_i(in1.rs1_used), .id_rs2_used_i(in1.rs2_used),
        .id_rd_i(in1.rd), .id_regwren_i(in1.regwren), .id_memren_i(in1.memren),
        .ex_redirect_i(in1.redirect), .dmem_busy_i(in1.busy),
        .stall_f_o(sf1), .stall_d_o(sd1), .flush_d_o(fd1), .flush_e_o(fe1),
        .fwd_a_o(fa1), .fwd_b_o(fb1), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t bub();
        in_t r;
        r = '0;
        return r;
    endfunction

    function automatic in_t ins(input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic wr, input logic mr);
        in_t r;
        r = '0;
        r.id_valid = 1'b1;
        r.rs1 = rs1; r.rs1_used = u1;
        r.rs2 = rs2; r.rs2_used = u2;
        r.rd = rd; r.regwren = wr; r.memren = mr;
        return r;
    endfunction

    function automatic in_t md(input in_t b, input logic rst, input logic red, input logic busy);
        in_t r;
        r = b;
        r.rst = rst; r.redirect = red; r.busy = busy;
        return r;
    endfunction

    function automatic exp_t ev(input logic sf, input logic sd, input logic fd, input logic fe,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic chk, input logic [31:0] sc, input logic [31:0] fc);
        exp_t r;
        r.sf = sf; r.sd = sd; r.fd = fd; r.fe = fe;
        r.fa = fa; r.fb = fb; r.chk_cnt = chk; r.scnt = sc; r.fcnt = fc;
        return r;
    endfunction

    function automatic exp_t e0(input logic [31:0] sc, input logic [31:0] fc);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, sc, fc);
    endfunction

    function automatic exp_t erst(input logic [31:0] sc, input logic [31:0] fc);
        return ev(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, sc, fc);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step1(input in_t i);
        @(negedge clk);
        in1 = i;
        #1;
    endtask

    // A load sitting in MEM must never be the producer for the EX consumer
    always @(negedge clk) begin
        if (in0.rst === 1'b0 && dut0.ex_q.valid === 1'b1) begin
            checks++;
            if (dut0.mem_q.valid && dut0.mem_q.memren && dut0.mem_q.regwren &&
                dut0.mem_q.rd != 5'd0 &&
                ((dut0.ex_q.rs1_used && dut0.ex_q.rs1 == dut0.mem_q.rd) ||
                 (dut0.ex_q.rs2_used && dut0.ex_q.rs2 == dut0.mem_q.rd))) begin
                errors++;
                $display("FAIL load_in_mem_vs_ex: got 1 expected 0");
            end
        end
    end

    vec_t vecs[$];

    initial begin
        errors = 0;
        checks = 0;
        in0 = md(bub(), 1'b1, 1'b0, 1'b0);
        in1 = md(bub(), 1'b1, 1'b0, 1'b0);

        // reset
        vecs.push_back('{md(bub(), 1'b1, 1'b0, 1'b0),
                         ev(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0)});
        vecs.push_back('{md(bub(), 1'b1, 1'b0, 1'b0), erst(32'd0, 32'd0)});
        // ALU -> ALU forwarding from MEM, then unrelated
        vecs.push_back('{ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0), e0(32'd0, 32'd0)});
        vecs.push_back('{ins(5'd5, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0), e0(32'd0, 32'd0)});
        vecs.push_back('{ins(5'd10, 1'b1, 5'd11, 1'b1, 5'd9, 1'b1, 1'b0),
                         ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 32'd0, 32'd0)});
        vecs.push_back('{bub(), e0(32'd0, 32'd0)});
        // load-use: one bubble, then WB forwarding on rs2
        vecs.push_back('{ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1), e0(32'd0, 32'd0)});
        vecs.push_back('{ins(5'd3, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0),
                         ev(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 32'd0, 32'd0)});
        vecs.push_back('{ins(5'd3, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0), e0(32'd1, 32'd0)});
        vecs.push_back('{bub(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 32'd1, 32'd0)});
        // load to x0 is never a hazard
        vecs.push_back('{ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1), e0(32'd1, 32'd0)});
        vecs.push_back('{ins(5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0), e0(32'd1, 32'd0)});
        vecs.push_back('{bub(), e0(32'd1, 32'd0)});
        // redirect overrides load-use
        vecs.push_back('{ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1), e0(32'd1, 32'd0)});
        vecs.push_back('{md(ins(5'd3, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0), 1'b0, 1'b1, 1'b0),
                         ev(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 32'd1, 32'd0)});
        vecs.push_back('{bub(), e0(32'd1, 32'd1)});
        // redirect held behind 3 busy cycles
        vecs.push_back('{md(bub(), 1'b1, 1'b0, 1'b0), erst(32'd1, 32'd1)});
        vecs.push_back('{md(bub(), 1'b0, 1'b1, 1'b1),
                         ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'd0, 32'd0)});
        vecs.push_back('{md(bub(), 1'b0, 1'b1, 1'b1),
                         ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'd1, 32'd0)});
        vecs.push_back('{md(bub(), 1'b0, 1'b1, 1'b1),
                         ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'd2, 32'd0)});
        vecs.push_back('{md(bub(), 1'b0, 1'b1, 1'b0), erst(32'd3, 32'd0)});
        vecs.push_back('{bub(), e0(32'd3, 32'd1)});
        // reset in the middle of a dependent sequence
        vecs.push_back('{ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0), e0(32'd3, 32'd1)});
        vecs.push_back('{ins(5'd5, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0), e0(32'd3, 32'd1)});
        vecs.push_back('{ins(5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0),
                         ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 32'd3, 32'd1)});
        vecs.push_back('{md(ins(5'd12, 1'b1, 5'd5, 1'b1, 5'd13, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0),
                         erst(32'd3, 32'd1)});
        vecs.push_back('{ins(5'd12, 1'b1, 5'd5, 1'b1, 5'd13, 1'b1, 1'b0), e0(32'd0, 32'd0)});
        vecs.push_back('{bub(), e0(32'd0, 32'd0)});
        // forwarding selects stay stable while frozen
        vecs.push_back('{ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0), e0(32'd0, 32'd0)});
        vecs.push_back('{ins(5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0), e0(32'd0, 32'd0)});
        vecs.push_back('{md(bub(), 1'b0, 1'b0, 1'b1),
                         ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 32'd0, 32'd0)});
        vecs.push_back('{md(bub(), 1'b0, 1'b0, 1'b1),
                         ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 32'd1, 32'd0)});
        vecs.push_back('{bub(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 32'd2, 32'd0)});
        vecs.push_back('{bub(), e0(32'd2, 32'd0)});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in0 = vecs[i].in;
            #1;
            check($sformatf("v%0d stall_f", i), {31'd0, sf0}, {31'd0, vecs[i].ex.sf});
            check($sformatf("v%0d stall_d", i), {31'd0, sd0}, {31'd0, vecs[i].ex.sd});
            check($sformatf("v%0d flush_d", i), {31'd0, fd0}, {31'd0, vecs[i].ex.fd});
            check($sformatf("v%0d flush_e", i), {31'd0, fe0}, {31'd0, vecs[i].ex.fe});
            check($sformatf("v%0d fwd_a", i), {30'd0, fa0}, {30'd0, vecs[i].ex.fa});
            check($sformatf("v%0d fwd_b", i), {30'd0, fb0}, {30'd0, vecs[i].ex.fb});
            if (vecs[i].ex.chk_cnt) begin
                check($sformatf("v%0d stall_cnt", i), sc0, vecs[i].ex.scnt);
                check($sformatf("v%0d flush_cnt", i), fc0, vecs[i].ex.fcnt);
            end
        end
        in0 = bub();

        // No forwarding: producer in EX costs two stall cycles
        step1(md(bub(), 1'b1, 1'b0, 1'b0));
        check("nf rst flush_d", {31'd0, fd1}, 32'd1);
        step1(ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0));
        check("nf addi stall_d", {31'd0, sd1}, 32'd0);
        check("nf rst stall_cnt", {28'd0, sc1}, 32'd0);
        step1(ins(5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0));
        check("nf ex stall_f", {31'd0, sf1}, 32'd1);
        check("nf ex stall_d", {31'd0, sd1}, 32'd1);
        check("nf ex flush_e", {31'd0, fe1}, 32'd1);
        step1(ins(5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0));
        check("nf mem stall_d", {31'd0, sd1}, 32'd1);
        step1(ins(5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0));
        check("nf wb stall_d", {31'd0, sd1}, 32'd0);
        check("nf 2stall cnt", {28'd0, sc1}, 32'd2);
        step1(bub());
        check("nf fwd_a", {30'd0, fa1}, 32'd0);
        check("nf fwd_b", {30'd0, fb1}, 32'd0);
        // No forwarding: producer already in MEM costs one stall cycle
        step1(ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0));
        step1(ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0));
        check("nf unrel stall_d", {31'd0, sd1}, 32'd0);
        step1(ins(5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0));
        check("nf mem1 stall_d", {31'd0, sd1}, 32'd1);
        step1(ins(5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0));
        check("nf mem1 release", {31'd0, sd1}, 32'd0);
        check("nf 3stall cnt", {28'd0, sc1}, 32'd3);

        // 4-bit counters wrap modulo 16
        for (int i = 0; i < 16; i++) begin
            step1(md(bub(), 1'b0, 1'b1, 1'b0));
            if (i == 15) check("flush_cnt at max", {28'd0, fc1}, 32'd15);
        end
        step1(bub());
        check("flush_cnt wrap", {28'd0, fc1}, 32'd0);
        for (int i = 0; i < 13; i++) begin
            step1(md(bub(), 1'b0, 1'b0, 1'b1));
            if (i == 12) check("stall_cnt at max", {28'd0, sc1}, 32'd15);
        end
        step1(bub());
        check("stall_cnt wrap", {28'd0, sc1}, 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
